retire_rat: RTL and testbench
=============================

RETIRE_RAT -- requirements
Module: retire_rat

Interface
REQ-001 Parameter DISPATCH_WIDTH, 2, number of commit lanes; lane 0 is oldest.
REQ-002 Parameter PHYS_REGS_ADDR_WIDTH, 6, physical register index width (64 physical registers).
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  synchronous, active-high reset.
REQ-005 Port commit_en[0:DISPATCH_WIDTH-1]  input  1 each  lane carries a retiring instruction this cycle.
REQ-006 Port commit_arch_rd[0:DISPATCH_WIDTH-1]  input  5 each  architectural destination; 0 = no destination.
REQ-007 Port commit_phys_rd[0:DISPATCH_WIDTH-1]  input  PHYS_REGS_ADDR_WIDTH each  physical register holding the result.
REQ-008 Port free_en[0:DISPATCH_WIDTH-1]  output  1 each  lane returns a register to the free list.
REQ-009 Port free_phys_rd[0:DISPATCH_WIDTH-1]  output  PHYS_REGS_ADDR_WIDTH each  register being freed.
REQ-010 Port rd_arch_addr  input  5  committed-map lookup address (recovery/debug).
REQ-011 Port rd_phys  output  PHYS_REGS_ADDR_WIDTH  committed mapping of rd_arch_addr.
REQ-012 Port retire_count  output  64  retired-instruction count (minstret source).

Function
REQ-013 The block SHALL hold a 32-entry committed map: architectural register -> physical register.
REQ-014 The block SHALL process lanes in order, lane 0 before lane 1, within one cycle.
REQ-015 Lane i with commit_en=1 and arch_rd!=0 SHALL write map[arch_rd]=phys_rd and free the previous mapping.
REQ-016 The previous mapping SHALL be the map value after all older lanes in the same cycle have been applied.
REQ-017 If lanes 0 and 1 share arch_rd (!=0): map ends at lane 1 phys_rd, lane 0 frees old map value, and lane 1 frees lane 0 phys_rd.
REQ-018 arch_rd=0 SHALL leave the map unchanged and free nothing; rename never allocates for x0.
REQ-019 map[0] SHALL always read physical register 0.
REQ-020 free_en/free_phys_rd SHALL be registered: they are valid exactly one cycle after the commit and hold for one cycle only.
REQ-021 free_en[i]=0 SHALL be driven whenever lane i did not free in the previous cycle; free_phys_rd is don't-care then.
REQ-022 Lane 1 commit without lane 0 SHALL be processed normally; in-order use by the ROB is not checked.
REQ-023 rd_phys SHALL be combinational from the current map register state; same-cycle commits are not bypassed.
REQ-024 Commits in consecutive cycles SHALL be accepted with no stall; the block has no backpressure.

Reset
REQ-025 On rst=1 at a clock edge, map[i] SHALL become i for i=0..31.
REQ-026 On reset, free_en SHALL become all 0, free_phys_rd 0, and retire_count 0.
REQ-027 A commit in a cycle with rst=1 SHALL be discarded: no map change, no free, no count.
REQ-028 Frees pending from the cycle before reset SHALL be dropped.

Configuration
REQ-029 Macro RETIRE_COUNT_EN defined: retire_count SHALL add the number of asserted commit_en each cycle (0, 1 or 2), wrapping at 2^64.
REQ-030 RETIRE_COUNT_EN undefined: no counter SHALL be built, and retire_count SHALL be constant 0.

Verification
REQ-031 Reset, then read every arch reg via rd_arch_addr -> rd_phys==index; free_en all 0.
REQ-032 Lane 0 commit arch_rd=5 phys=40 -> next cycle free_en[0]=1, free_phys_rd[0]=5; rd_phys(5)=40; count=1.
REQ-033 Both lanes arch_rd=7 with phys 41 and 42 -> next cycle frees 7 (lane 0) and 41 (lane 1); map[7]=42; count+=2.
REQ-034 Lane 0 arch_rd=0 phys=50 with lane 1 arch_rd=3 phys=51 -> free_en={0,1} with lane 1 freeing 3; map[0] stays 0; count+=2.
REQ-035 Commit arch_rd=9 phys=60 in the same cycle as rst=1 -> map[9]=9, no free next cycle, count=0.
REQ-036 RETIRE_COUNT_EN undefined, 10 dual commits -> retire_count==0; maps and frees identical to the defined build.

Source files
------------

// File: rtl/retire_rat.sv
// Retirement register alias table: committed arch->phys map, in-order lane frees, retire counter.
// Optional retired-instruction counter built only when RETIRE_COUNT_EN is defined.
module retire_rat #(
    parameter int DISPATCH_WIDTH       = 2,
    parameter int PHYS_REGS_ADDR_WIDTH = 6
) (
    input  logic                                                 clk,
    input  logic                                                 rst,
    input  logic [DISPATCH_WIDTH-1:0]                            commit_en,
    input  logic [DISPATCH_WIDTH-1:0][4:0]                       commit_arch_rd,
    input  logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0]  commit_phys_rd,
    output logic [DISPATCH_WIDTH-1:0]                            free_en,
    output logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0]  free_phys_rd,
    input  logic [4:0]                                           rd_arch_addr,
    output logic [PHYS_REGS_ADDR_WIDTH-1:0]                      rd_phys,
    output logic [63:0]                                          retire_count
);
    localparam int PW = PHYS_REGS_ADDR_WIDTH;

    logic [31:0][PW-1:0]              map_q, map_d;
    logic [DISPATCH_WIDTH-1:0]        free_en_d;
    logic [DISPATCH_WIDTH-1:0][PW-1:0] free_phys_d;

    // Lanes applied oldest-first onto a working copy, so each lane frees the
    // mapping left by older lanes in the same cycle. Entry 0 is never written.
    always_comb begin
        map_d       = map_q;
        free_en_d   = '0;
        free_phys_d = '0;
        for (int i = 0; i < DISPATCH_WIDTH; i++) begin
            if (commit_en[i] && commit_arch_rd[i] != 5'd0) begin
                free_en_d[i]                = 1'b1;
                free_phys_d[i]              = map_d[commit_arch_rd[i]];
                map_d[commit_arch_rd[i]]    = commit_phys_rd[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) map_q[i] <= PW'(i);
            free_en      <= '0;
            free_phys_rd <= '0;
        end else begin
            map_q        <= map_d;
            free_en      <= free_en_d;
            free_phys_rd <= free_phys_d;
        end
    end

    assign rd_phys = map_q[rd_arch_addr];

`ifdef RETIRE_COUNT_EN
    logic [63:0] count_q, count_inc;

    always_comb begin
        count_inc = '0;
        for (int i = 0; i < DISPATCH_WIDTH; i++) count_inc = count_inc + 64'(commit_en[i]);
    end

    always_ff @(posedge clk) begin
        if (rst) count_q <= '0;
        else     count_q <= count_q + count_inc;
    end

    assign retire_count = count_q;
`else
    assign retire_count = '0;
`endif

endmodule

// File: tb/tb_retire_rat.sv
// Self-checking bench for retire_rat: directed scenarios then random commits vs an array model.
module tb_retire_rat;
    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       commit_en;
    logic [1:0][4:0]  commit_arch_rd;
    logic [1:0][5:0]  commit_phys_rd;
    logic [1:0]       free_en;
    logic [1:0][5:0]  free_phys_rd;
    logic [4:0]       rd_arch_addr;
    logic [5:0]       rd_phys;
    logic [63:0]      retire_count;

    int checks   = 0;
    int failures = 0;

    int              mmap [32];
    longint unsigned mcount;
    bit              exp_fen [2];
    int              exp_fphys [2];

    retire_rat #(.DISPATCH_WIDTH(2), .PHYS_REGS_ADDR_WIDTH(6)) dut (
        .clk(clk), .rst(rst), .commit_en(commit_en),
        .commit_arch_rd(commit_arch_rd), .commit_phys_rd(commit_phys_rd),
        .free_en(free_en), .free_phys_rd(free_phys_rd),
        .rd_arch_addr(rd_arch_addr), .rd_phys(rd_phys),
        .retire_count(retire_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: drive lanes (and optionally reset), update model, check frees/count after the edge.
    task automatic step(input bit e0, input int a0, input int p0,
                        input bit e1, input int a1, input int p1, input bit r);
        bit en [2];
        int ar [2];
        int pr [2];
        en = '{e0, e1}; ar = '{a0, a1}; pr = '{p0, p1};
        @(negedge clk);
        rst = r;
        commit_en      = {e1, e0};
        commit_arch_rd = {5'(a1), 5'(a0)};
        commit_phys_rd = {6'(p1), 6'(p0)};
        if (r) begin
            for (int k = 0; k < 32; k++) mmap[k] = k;
            mcount = 0;
            exp_fen = '{0, 0};
        end else begin
            for (int l = 0; l < 2; l++) begin
                exp_fen[l] = en[l] && ar[l] != 0;
                if (exp_fen[l]) begin
                    exp_fphys[l] = mmap[ar[l]];
                    mmap[ar[l]]  = pr[l];
                end
                if (en[l]) mcount++;
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        commit_en = '0;
        for (int l = 0; l < 2; l++) begin
            chk($sformatf("free_en[%0d]", l), 64'(free_en[l]), 64'(exp_fen[l]));
            if (exp_fen[l]) chk($sformatf("free_phys_rd[%0d]", l), 64'(free_phys_rd[l]), 64'(exp_fphys[l]));
        end
`ifdef RETIRE_COUNT_EN
        chk("retire_count", retire_count, mcount);
`else
        chk("retire_count", retire_count, 64'd0);
`endif
    endtask

    task automatic look(input int a);
        rd_arch_addr = 5'(a);
        #1;
        chk($sformatf("rd_phys(%0d)", a), 64'(rd_phys), 64'(mmap[a]));
    endtask

    initial begin
        rst = 1'b0; commit_en = '0; commit_arch_rd = '0; commit_phys_rd = '0; rd_arch_addr = '0;
        for (int k = 0; k < 32; k++) mmap[k] = k;
        mcount = 0;

        // Reset, full map readback.
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0);
        for (int a = 0; a < 32; a++) look(a);

        // Single lane-0 commit.
        step(1, 5, 40, 0, 0, 0, 0);
        look(5);
        // Frees hold one cycle only.
        step(0, 0, 0, 0, 0, 0, 0);

        // Both lanes same arch reg.
        step(1, 7, 41, 1, 7, 42, 0);
        look(7);

        // x0 on lane 0, normal lane 1.
        step(1, 0, 50, 1, 3, 51, 0);
        look(0); look(3);

        // Lane 1 alone.
        step(0, 0, 0, 1, 12, 33, 0);
        look(12);

        // Commit pending, then reset with a commit in the reset cycle: frees dropped, commit discarded.
        step(1, 4, 20, 0, 0, 0, 0);
        step(1, 9, 60, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0);
        look(9); look(4);

        // Ten back-to-back dual commits.
        for (int n = 0; n < 10; n++) step(1, 1 + n, 10 + n, 1, 20 + n, 40 + n, 0);
        for (int a = 0; a < 32; a++) look(a);

        // Random traffic with occasional reset and forced same-register collisions.
        for (int n = 0; n < 400; n++) begin
            int a0, a1;
            a0 = $urandom_range(0, 31);
            a1 = ($urandom_range(0, 3) == 0) ? a0 : $urandom_range(0, 31);
            if ($urandom_range(0, 7) == 0) a0 = 0;
            step(1'($urandom_range(0, 1)), a0, $urandom_range(0, 63),
                 1'($urandom_range(0, 1)), a1, $urandom_range(0, 63),
                 $urandom_range(0, 29) == 0);
            look($urandom_range(0, 31));
        end
        for (int a = 0; a < 32; a++) look(a);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
